// File: rtl/mem_access_initiator_if.sv
// mem_access_initiator_if: request/response handshake and byte-wide data memory bus.
// The master modport is the initiator's view; the slave modport is the pipeline/memory side.
interface mem_access_initiator_if #(
    parameter int N      = 64,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        icode;
    logic [N-1:0]      valE;
    logic [N-1:0]      valA;
    logic [N-1:0]      valP;
    logic              resp_valid;
    logic              resp_ready;
    logic [N-1:0]      valM;
    logic              dmem_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_wen;
    logic              mem_ren;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, icode, valE, valA, valP, resp_ready, mem_rdata,
        output req_ready, resp_valid, valM, dmem_err, mem_addr, mem_wdata, mem_wen, mem_ren
    );

    modport slave (
        output req_valid, icode, valE, valA, valP, resp_ready, mem_rdata,
        input  req_ready, resp_valid, valM, dmem_err, mem_addr, mem_wdata, mem_wen, mem_ren
    );
endinterface

// File: rtl/mem_access_initiator.sv
// mem_access_initiator: Y86-64 memory-stage initiator that turns one 64-bit load/store
// into eight little-endian byte accesses and returns valM/dmem_err through a handshake.
// Optional macro MEM_ALIGN_CHECK_EN: when defined, a base address that is not 8-byte
// aligned is rejected with dmem_err like an out-of-range address.
module mem_access_initiator #(
    parameter int N        = 64,
    parameter int ADDR_W   = 16,
    parameter int MEM_SIZE = 65536
) (
    input logic clk,
    input logic reset,
    mem_access_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

    state_t            state;
    state_t            nextState;
    logic [2:0]        byteCnt;
    logic [ADDR_W-1:0] baseAddr;
    logic [N-1:0]      wordData;
    logic [N-1:0]      valMReg;
    logic              errReg;
    logic              isWrite;
    logic              isRead;
    logic              badAddr;
    logic              accept;
    logic [N-1:0]      reqAddr;
    logic [N-1:0]      reqData;
    logic [N:0]        lastByte;

    assign accept       = state == IDLE && bus.req_valid;
    assign bus.valM     = valMReg;
    assign bus.dmem_err = errReg;

    // Decode the request: operation, address source, write data and address legality.
    // The last byte address is formed one bit wider than the operand so huge values cannot wrap.
    always_comb begin
        isWrite  = bus.icode == 4'h4 || bus.icode == 4'hA || bus.icode == 4'h8;
        isRead   = bus.icode == 4'h5 || bus.icode == 4'hB || bus.icode == 4'h9;
        reqAddr  = (bus.icode == 4'hB || bus.icode == 4'h9) ? bus.valA : bus.valE;
        reqData  = bus.icode == 4'h8 ? bus.valP : bus.valA;
        lastByte = {1'b0, reqAddr} + (N+1)'(7);
        badAddr  = lastByte > (N+1)'(MEM_SIZE - 1);
`ifdef MEM_ALIGN_CHECK_EN
        badAddr  = badAddr || reqAddr[2:0] != 3'd0;
`endif
    end

    // State register; async reset drops the strobes immediately since they decode from state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic and all handshake/strobe outputs.
    always_comb begin
        nextState      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_ren    = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    nextState = (!isWrite && !isRead) || badAddr ? RESP : isWrite ? WRITE : READ;
            end
            WRITE: begin
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = baseAddr + ADDR_W'(byteCnt);
                bus.mem_wdata = wordData[{byteCnt, 3'b000} +: 8];
                nextState     = byteCnt == 3'd7 ? RESP : WRITE;
            end
            READ: begin
                bus.mem_ren  = 1'b1;
                bus.mem_addr = baseAddr + ADDR_W'(byteCnt);
                nextState    = byteCnt == 3'd7 ? DRAIN : READ;
            end
            DRAIN: nextState = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                nextState      = bus.resp_ready ? IDLE : RESP;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch the request at accept, step the byte counter, and gather read bytes
    // one cycle behind their strobe (the last byte lands during DRAIN).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byteCnt  <= '0;
            baseAddr <= '0;
            wordData <= '0;
            valMReg  <= '0;
            errReg   <= 1'b0;
        end else begin
            if (accept) begin
                byteCnt  <= '0;
                baseAddr <= reqAddr[ADDR_W-1:0];
                wordData <= reqData;
                valMReg  <= '0;
                errReg   <= badAddr && (isWrite || isRead);
            end else if (state == WRITE || state == READ) begin
                byteCnt <= byteCnt + 3'd1;
            end
            if (state == READ && byteCnt != 3'd0)
                valMReg[{byteCnt - 3'd1, 3'b000} +: 8] <= bus.mem_rdata;
            if (state == DRAIN)
                valMReg[N-1 -: 8] <= bus.mem_rdata;
        end
    end
endmodule
